// File: rtl/pcm_feed_ctrl_if.sv
// Bus bundle between pcm_feed_ctrl and its CPU register port, DMA streamer and audio FIFO.
// slave = the feed controller, master = the surrounding CPU/DMA/FIFO side.
interface pcm_feed_ctrl_if;
    logic [7:0]  cpu_wrdata;
    logic        cpu_write;
    logic        fifo_reset_req;
    logic        dma_enable;
    logic        aflow_ie;
    logic [7:0]  dma_data;
    logic        dma_valid;
    logic        dma_ready;
    logic        fifo_full;
    logic        fifo_almost_empty;
    logic        fifo_empty;
    logic [7:0]  fifo_wrdata;
    logic        fifo_write;
    logic        fifo_reset;
    logic        next_sample;
    logic        irq_aflow;
    logic        cpu_overflow;
    logic [15:0] underrun_count;

    modport slave (
        input  cpu_wrdata, cpu_write, fifo_reset_req, dma_enable, aflow_ie,
        input  dma_data, dma_valid, fifo_full, fifo_almost_empty, fifo_empty,
        output dma_ready, fifo_wrdata, fifo_write, fifo_reset, next_sample,
        output irq_aflow, cpu_overflow, underrun_count
    );

    modport master (
        output cpu_wrdata, cpu_write, fifo_reset_req, dma_enable, aflow_ie,
        output dma_data, dma_valid, fifo_full, fifo_almost_empty, fifo_empty,
        input  dma_ready, fifo_wrdata, fifo_write, fifo_reset, next_sample,
        input  irq_aflow, cpu_overflow, underrun_count
    );
endinterface

// File: rtl/pcm_feed_ctrl.sv
// PCM FIFO write-side controller: CPU/DMA write arbitration, flush sequencing, refill bursts
// and sample tick. Define PCM_FEED_STATS_EN to build the saturating underrun counter.
module pcm_feed_ctrl #(
    parameter int TICK_DIV  = 512,
    parameter int BURST_MAX = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    pcm_feed_ctrl_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, SETTLE} state_t;

    state_t         state_q, state_d;
    logic           hold_valid_q, hold_valid_d;
    logic [7:0]     hold_data_q, hold_data_d;
    logic [7:0]     burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic           cpu_overflow_q, cpu_overflow_d;
    logic           irq_aflow_q, irq_aflow_d;

    logic           flushing, settling, hold_drain, dma_ready, dma_xfer, tick_now;

    always_comb begin
        flushing   = (state_q == FLUSH);
        settling   = (state_q == SETTLE);
        hold_drain = hold_valid_q && !bus.fifo_full && !flushing && !settling;
        // A flush request in the same cycle aborts the burst before any byte is taken.
        dma_ready  = (state_q == FILL) && !hold_valid_q && !bus.fifo_full && !bus.fifo_reset_req;
        dma_xfer   = dma_ready && bus.dma_valid;
        tick_now   = (tick_q == TW'(TICK_DIV - 1));
    end

    always_comb begin
        hold_valid_d   = hold_valid_q && !hold_drain;
        hold_data_d    = hold_data_q;
        cpu_overflow_d = cpu_overflow_q;
        if (flushing) begin
            hold_valid_d   = 1'b0;
            cpu_overflow_d = 1'b0;
        end else if (bus.cpu_write) begin
            if (!hold_valid_q || hold_drain) begin
                hold_valid_d = 1'b1;
                hold_data_d  = bus.cpu_wrdata;
            end else begin
                cpu_overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = dma_xfer ? burst_cnt_q + 8'd1 : burst_cnt_q;
        if (bus.fifo_reset_req) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.dma_enable && bus.fifo_almost_empty) begin
                        state_d     = FILL;
                        burst_cnt_d = 8'd0;
                    end
                end
                FILL: begin
                    if (bus.fifo_full || !bus.dma_enable ||
                        (dma_xfer && burst_cnt_q == 8'(BURST_MAX - 1)))
                        state_d = IDLE;
                end
                FLUSH:   state_d = SETTLE;
                SETTLE:  if (bus.fifo_empty) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_d      = tick_now ? '0 : tick_q + 1'b1;
        irq_aflow_d = bus.aflow_ie && bus.fifo_almost_empty && !bus.dma_enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hold_valid_q   <= 1'b0;
            hold_data_q    <= 8'h00;
            burst_cnt_q    <= 8'd0;
            tick_q         <= '0;
            cpu_overflow_q <= 1'b0;
            irq_aflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            burst_cnt_q    <= burst_cnt_d;
            tick_q         <= tick_d;
            cpu_overflow_q <= cpu_overflow_d;
            irq_aflow_q    <= irq_aflow_d;
        end
    end

    assign bus.dma_ready    = dma_ready;
    assign bus.fifo_write   = hold_drain || dma_xfer;
    assign bus.fifo_wrdata  = hold_drain ? hold_data_q : (dma_xfer ? bus.dma_data : 8'h00);
    assign bus.fifo_reset   = flushing;
    assign bus.next_sample  = tick_now;
    assign bus.irq_aflow    = irq_aflow_q;
    assign bus.cpu_overflow = cpu_overflow_q;

`ifdef PCM_FEED_STATS_EN
    logic [15:0] underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (flushing)
            underrun_d = 16'h0000;
        else if (tick_now && bus.fifo_empty && !settling && underrun_q != 16'hFFFF)
            underrun_d = underrun_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underrun_q <= 16'h0000;
        else        underrun_q <= underrun_d;
    end

    assign bus.underrun_count = underrun_q;
`else
    assign bus.underrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pcm_feed_ctrl.sv
// Self-checking bench for pcm_feed_ctrl: directed vector table, reset/tick sequences and
// randomized traffic checked against a queue-based reference model.
module tb_pcm_feed_ctrl;
    localparam int TICK_DIV  = 4;
    localparam int BURST_MAX = 4;
    localparam int M_IDLE = 0, M_FILL = 1, M_FLUSH = 2, M_SETTLE = 3;

    logic clk;
    logic rst_n;
    pcm_feed_ctrl_if bus();

    pcm_feed_ctrl #(.TICK_DIV(TICK_DIV), .BURST_MAX(BURST_MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ticks_seen = 0;

    // reference model state
    logic [7:0] m_hold[$];
    int m_mode, m_burst, m_cyc, m_under;
    bit m_ovf, m_irq;

    typedef struct {
        logic cw; logic [7:0] cd; logic req, en, ae, dv; logic [7:0] dd; logic full, empty;
        logic x_wr; logic [7:0] x_wd; logic x_rdy, x_ovf, x_rst;
    } vec_t;
    vec_t tv[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_hold.delete();
        m_mode = M_IDLE; m_burst = 0; m_cyc = 0; m_under = 0; m_ovf = 0; m_irq = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dma_ready"},   bus.dma_ready, 0);
        chk({tag, "_fifo_write"},  bus.fifo_write, 0);
        chk({tag, "_fifo_wrdata"}, bus.fifo_wrdata, 0);
        chk({tag, "_fifo_reset"},  bus.fifo_reset, 0);
        chk({tag, "_next_sample"}, bus.next_sample, 0);
        chk({tag, "_irq_aflow"},   bus.irq_aflow, 0);
        chk({tag, "_overflow"},    bus.cpu_overflow, 0);
        chk({tag, "_underrun"},    bus.underrun_count, 0);
    endtask

    // Called at a negedge with inputs already driven: check, advance model, wait next negedge.
    task automatic step();
        bit fl, st, drain, rdy, xfer, wr, tick;
        logic [7:0] wd;
        int exp_under;
        #1;
        fl    = (m_mode == M_FLUSH);
        st    = (m_mode == M_SETTLE);
        drain = (m_hold.size() != 0) && !bus.fifo_full && !fl && !st;
        rdy   = (m_mode == M_FILL) && (m_hold.size() == 0) && !bus.fifo_full && !bus.fifo_reset_req;
        xfer  = rdy && bus.dma_valid;
        wr    = drain || xfer;
        wd    = drain ? m_hold[0] : bus.dma_data;
        tick  = (m_cyc % TICK_DIV) == TICK_DIV - 1;
`ifdef PCM_FEED_STATS_EN
        exp_under = m_under;
`else
        exp_under = 0;
`endif
        chk("fifo_write", bus.fifo_write, wr);
        if (wr) chk("fifo_wrdata", bus.fifo_wrdata, wd);
        chk("dma_ready", bus.dma_ready, rdy);
        chk("fifo_reset", bus.fifo_reset, fl);
        chk("next_sample", bus.next_sample, tick);
        chk("irq_aflow", bus.irq_aflow, m_irq);
        chk("cpu_overflow", bus.cpu_overflow, m_ovf);
        chk("underrun_count", bus.underrun_count, exp_under);
        if (bus.next_sample) ticks_seen++;

        if (drain) void'(m_hold.pop_front());
        if (fl) begin
            m_hold.delete();
            m_ovf = 0;
        end else if (bus.cpu_write) begin
            if (m_hold.size() == 0) m_hold.push_back(bus.cpu_wrdata);
            else m_ovf = 1;
        end
        if (fl) m_under = 0;
        else if (tick && bus.fifo_empty && !st && m_under < 65535) m_under++;
        m_irq = bus.aflow_ie && bus.fifo_almost_empty && !bus.dma_enable;
        if (bus.fifo_reset_req) m_mode = M_FLUSH;
        else begin
            case (m_mode)
                M_IDLE: if (bus.dma_enable && bus.fifo_almost_empty) begin
                    m_mode = M_FILL; m_burst = 0;
                end
                M_FILL: begin
                    if (xfer) m_burst++;
                    if (bus.fifo_full || !bus.dma_enable || m_burst == BURST_MAX) m_mode = M_IDLE;
                end
                M_FLUSH:  m_mode = M_SETTLE;
                default:  if (bus.fifo_empty) m_mode = M_IDLE;
            endcase
        end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic drive_zero();
        bus.cpu_wrdata = 8'h00; bus.cpu_write = 0; bus.fifo_reset_req = 0; bus.dma_enable = 0;
        bus.aflow_ie = 0; bus.dma_data = 8'h00; bus.dma_valid = 0; bus.fifo_full = 0;
        bus.fifo_almost_empty = 0; bus.fifo_empty = 1;
    endtask

    initial begin
        //        cw  cd    req en ae dv dd    full empty  wr wd    rdy ovf rst
        tv[0]  = '{1, 8'h01, 0, 0, 0, 0, 8'h00, 1, 1,    0, 8'h00, 0, 0, 0};
        tv[1]  = '{1, 8'h02, 0, 0, 0, 0, 8'h00, 1, 1,    0, 8'h00, 0, 0, 0};
        tv[2]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 1,    0, 8'h00, 0, 1, 0};
        tv[3]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1,    1, 8'h01, 0, 1, 0};
        tv[4]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1,    0, 8'h00, 0, 1, 0};
        tv[5]  = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1,    0, 8'h00, 0, 1, 0};
        tv[6]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,    0, 8'h00, 0, 1, 1};
        tv[7]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,    0, 8'h00, 0, 0, 0};
        tv[8]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[9]  = '{0, 8'h00, 0, 1, 1, 1, 8'h10, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[10] = '{1, 8'hA5, 0, 1, 1, 1, 8'h10, 0, 1,    1, 8'h10, 1, 0, 0};
        tv[11] = '{0, 8'h00, 0, 1, 1, 1, 8'h11, 0, 1,    1, 8'hA5, 0, 0, 0};
        tv[12] = '{0, 8'h00, 0, 1, 1, 1, 8'h11, 0, 1,    1, 8'h11, 1, 0, 0};
        tv[13] = '{0, 8'h00, 0, 1, 1, 1, 8'h12, 0, 1,    1, 8'h12, 1, 0, 0};
        tv[14] = '{0, 8'h00, 0, 1, 1, 1, 8'h13, 0, 1,    1, 8'h13, 1, 0, 0};
        tv[15] = '{0, 8'h00, 0, 1, 1, 1, 8'h14, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[16] = '{0, 8'h00, 0, 1, 1, 1, 8'h14, 0, 1,    1, 8'h14, 1, 0, 0};
        tv[17] = '{0, 8'h00, 0, 0, 1, 1, 8'h15, 0, 1,    1, 8'h15, 1, 0, 0};
        tv[18] = '{0, 8'h00, 0, 0, 1, 1, 8'h16, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[19] = '{0, 8'h00, 0, 1, 1, 1, 8'h20, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[20] = '{0, 8'h00, 0, 1, 1, 1, 8'h20, 0, 1,    1, 8'h20, 1, 0, 0};
        tv[21] = '{0, 8'h00, 1, 1, 1, 1, 8'h21, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[22] = '{1, 8'h77, 0, 1, 1, 1, 8'h21, 0, 0,    0, 8'h00, 0, 0, 1};
        tv[23] = '{1, 8'h66, 0, 1, 1, 1, 8'h21, 0, 0,    0, 8'h00, 0, 0, 0};
        tv[24] = '{0, 8'h00, 0, 1, 1, 1, 8'h21, 0, 1,    0, 8'h00, 0, 0, 0};
        tv[25] = '{0, 8'h00, 0, 1, 1, 1, 8'h21, 0, 1,    1, 8'h66, 0, 0, 0};
        tv[26] = '{0, 8'h00, 0, 1, 1, 1, 8'h22, 0, 1,    1, 8'h22, 1, 0, 0};

        rst_n = 1'b0;
        drive_zero();
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: overflow, flush, CPU priority, burst length, flush mid-burst.
        for (int i = 0; i < 27; i++) begin
            bus.cpu_write = tv[i].cw; bus.cpu_wrdata = tv[i].cd; bus.fifo_reset_req = tv[i].req;
            bus.dma_enable = tv[i].en; bus.fifo_almost_empty = tv[i].ae; bus.dma_valid = tv[i].dv;
            bus.dma_data = tv[i].dd; bus.fifo_full = tv[i].full; bus.fifo_empty = tv[i].empty;
            #1;
            if (bus.fifo_write !== tv[i].x_wr || bus.dma_ready !== tv[i].x_rdy ||
                bus.cpu_overflow !== tv[i].x_ovf || bus.fifo_reset !== tv[i].x_rst ||
                (tv[i].x_wr && bus.fifo_wrdata !== tv[i].x_wd)) begin
                n_chk++;
                $display("FAIL vec%0d: got wr=%b wd=%h rdy=%b ovf=%b rst=%b, expected wr=%b wd=%h rdy=%b ovf=%b rst=%b",
                         i, bus.fifo_write, bus.fifo_wrdata, bus.dma_ready, bus.cpu_overflow, bus.fifo_reset,
                         tv[i].x_wr, tv[i].x_wd, tv[i].x_rdy, tv[i].x_ovf, tv[i].x_rst);
            end else begin
                n_chk++;
                n_pass++;
            end
            step();
        end

        // Asynchronous reset in the middle of a burst with DMA still offering data.
        bus.cpu_write = 0; bus.fifo_reset_req = 0; bus.aflow_ie = 1; bus.dma_valid = 1;
        bus.dma_enable = 1; bus.fifo_almost_empty = 1; bus.dma_data = 8'h30;
        chk("pre_reset_in_fill", bus.dma_ready, 1);
        rst_n = 1'b0;
        #1 chk_all_zero("mid_burst_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            bus.dma_data = 8'h31 + 8'(i);
            step();
        end

        // Tick spacing and underrun statistics with the FIFO held empty.
        rst_n = 1'b0;
        drive_zero();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ticks_seen = 0;
        repeat (20) step();
        chk("tick_pulses", ticks_seen, 5);
`ifdef PCM_FEED_STATS_EN
        #1 chk("underrun_after_20", bus.underrun_count, 5);
`else
        #1 chk("underrun_after_20", bus.underrun_count, 0);
`endif
        @(negedge clk);
        m_cyc++;
        if (m_cyc % TICK_DIV == 0) ;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bus.cpu_write = ($urandom_range(3) == 0);
            bus.cpu_wrdata = 8'($urandom);
            bus.fifo_reset_req = ($urandom_range(39) == 0);
            bus.dma_enable = ($urandom_range(7) != 0);
            bus.fifo_almost_empty = 1'($urandom_range(1));
            bus.dma_valid = ($urandom_range(3) != 0);
            bus.dma_data = 8'($urandom);
            bus.fifo_full = ($urandom_range(4) == 0);
            bus.fifo_empty = ($urandom_range(2) == 0);
            bus.aflow_ie = 1'($urandom_range(1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pcm_feed_ctrl.md
Name: pcm_feed_ctrl

Overview:
Write-side controller for the PCM audio FIFO. It arbitrates FIFO write access between the CPU register port and a DMA byte streamer, sequences FIFO flushes, and runs low-watermark refill bursts. It also generates the next_sample tick consumed by the PCM playback block, and sits between the bus/DMA logic and the pcm block's FIFO interface.

Parameters:
TICK_DIV, 512, clk cycles per next_sample pulse (>=2)
BURST_MAX, 64, max DMA bytes accepted per refill burst (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_wrdata  in  8  CPU PCM data byte
cpu_write  in  1  one-cycle CPU write strobe
fifo_reset_req  in  1  one-cycle CPU flush request
dma_enable  in  1  DMA streaming enabled (level)
aflow_ie  in  1  almost-empty interrupt enable
dma_data  in  8  DMA byte
dma_valid  in  1  DMA byte valid
dma_ready  out  1  DMA byte accepted this cycle
fifo_full  in  1  from audio FIFO
fifo_almost_empty  in  1  from audio FIFO
fifo_empty  in  1  from audio FIFO
fifo_wrdata  out  8  FIFO write data
fifo_write  out  1  FIFO write enable
fifo_reset  out  1  FIFO synchronous reset pulse
next_sample  out  1  one-cycle sample tick to pcm
irq_aflow  out  1  registered almost-empty interrupt
cpu_overflow  out  1  sticky: CPU byte dropped
underrun_count  out  16  see Optional Feature

Behaviour:
- Reset (rst_n low, async): state=IDLE, hold empty, burst count 0, tick counter 0. All outputs 0.
- CPU hold register (1 byte):
  - cpu_write captures cpu_wrdata into hold when hold is empty, or when hold drains in the same cycle.
  - cpu_write while hold is full and not draining: byte dropped, cpu_overflow set.
  - cpu_overflow is cleared only by reset or flush.
- Write port (combinational):
  - If hold is valid and !fifo_full: fifo_write=1, fifo_wrdata=hold, hold empties at the clock edge.
  - Else if dma_ready && dma_valid: fifo_write=1, fifo_wrdata=dma_data.
  - Else fifo_write=0.
  - The CPU always has priority. It never writes when fifo_full; the hold simply waits.
- dma_ready = (state==FILL) && !hold_valid && !fifo_full. A DMA transfer occurs on dma_valid && dma_ready.
- FSM states: IDLE, FILL, FLUSH, SETTLE.
  - IDLE -> FILL when dma_enable && fifo_almost_empty. Burst count is cleared on entry.
  - FILL -> IDLE on any of:
    - fifo_full
    - !dma_enable
    - burst count reaching BURST_MAX; the count increments per DMA transfer, so exactly BURST_MAX bytes are accepted.
  - FILL re-enters from IDLE on the next cycle if almost_empty is still true.
  - Any state -> FLUSH on fifo_reset_req. fifo_reset_req has priority over all other transitions and aborts a burst mid-transfer; no DMA byte is accepted that cycle.
  - FLUSH (1 cycle):
    - fifo_reset=1, fifo_write=0, dma_ready=0.
    - Hold cleared and cpu_overflow cleared.
    - A cpu_write in this cycle is discarded.
    - Next state: SETTLE.
  - SETTLE: fifo_write=0, dma_ready=0; CPU writes go to the hold and wait. -> IDLE when fifo_empty. fifo_reset_req in SETTLE restarts FLUSH.
- Tick generator:
  - Counter 0..TICK_DIV-1 that wraps.
  - next_sample=1 for one cycle when the counter equals TICK_DIV-1.
  - Free-running and unaffected by flush.
- irq_aflow: registered, = aflow_ie && fifo_almost_empty && !dma_enable. It is 1 cycle later than its inputs.
- Simultaneous events:
  - cpu_write and a hold drain in the same cycle: the hold reloads with the new byte; no overflow.
  - Hold drain and DMA valid in the same cycle: the DMA byte stalls (dma_ready=0).

Optional Feature:
PCM_FEED_STATS_EN
- Defined: 16-bit underrun_count increments on each next_sample pulse while fifo_empty and state is not FLUSH/SETTLE. It saturates at 0xFFFF and is cleared by reset or FLUSH.
- Undefined: underrun_count tied to 0 and no counter logic.

Test Plan:
- Reset mid-burst: assert rst_n=0 during FILL with dma_valid=1 -> dma_ready, fifo_write, fifo_reset, next_sample, irq_aflow all 0 immediately; state IDLE after release.
- Refill burst: BURST_MAX=4, dma_enable=1, almost_empty=1, dma_valid constant, FIFO never full -> exactly 4 writes with DMA bytes in order, 1 IDLE cycle, then a new burst.
- CPU priority: cpu_write 0xA5 while in FILL with DMA streaming 0x10,0x11 -> 0xA5 written the cycle after the strobe, DMA stalls one cycle, byte order 0x10,0xA5,0x11 (or 0xA5 first if the strobe precedes the first DMA byte); cpu_overflow=0.
- Overflow: fifo_full=1, cpu_write 0x01 then 0x02 -> hold keeps 0x01, cpu_overflow=1; drop fifo_full -> 0x01 written once, no 0x02.
- Flush: fifo_reset_req during FILL -> fifo_reset high exactly 1 cycle, dma_ready 0 until fifo_empty observed, cpu_overflow cleared, then IDLE.
- Tick/stats: TICK_DIV=4, fifo_empty=1 for 20 cycles -> next_sample every 4th cycle (5 pulses); with PCM_FEED_STATS_EN underrun_count=5, without it 0.
